// File: rtl/proc_dpath_imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with an elastic val/rdy pipeline and tag sideband.
// Optional Z-type CSR uimm decode is enabled by defining PROC_DPATH_IMM_GEN_ZIMM_EN.
module proc_dpath_imm_gen_pipe #(
  parameter int p_xlen      = 32,
  parameter int p_nstages   = 2,
  parameter int p_tag_nbits = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [2:0]             in_imm_type,
  input  logic [31:0]            in_inst,
  input  logic [p_tag_nbits-1:0] in_tag,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_xlen-1:0]      out_imm,
  output logic [p_tag_nbits-1:0] out_tag,
  output logic                   out_err,
  output logic [7:0]             err_count
);

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_type_e;

  logic [p_xlen-1:0]      w_imm;
  logic                   w_err;
  logic [p_nstages-1:0]   w_ld;
  logic [p_nstages-1:0]   w_go;

  logic [p_nstages-1:0]   r_val;
  logic [p_xlen-1:0]      r_imm [p_nstages];
  logic                   r_err [p_nstages];
  logic [p_tag_nbits-1:0] r_tag [p_nstages];
  logic [7:0]             r_err_count;

  // Start from a full sign fill, then overwrite the low field bits per format.
  always_comb begin
    w_imm = {p_xlen{in_inst[31]}};
    w_err = 1'b0;
    case (in_imm_type)
      IMM_I: w_imm[10:0] = in_inst[30:20];
      IMM_S: w_imm[10:0] = {in_inst[30:25], in_inst[11:7]};
      IMM_B: w_imm[11:0] = {in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      IMM_U: w_imm[31:0] = {in_inst[31:12], 12'b0};
      IMM_J: w_imm[19:0] = {in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
`ifdef PROC_DPATH_IMM_GEN_ZIMM_EN
      IMM_Z: begin
        w_imm      = '0;
        w_imm[4:0] = in_inst[19:15];
      end
`else
      IMM_Z: begin
        w_imm = '0;
        w_err = 1'b1;
      end
`endif
      default: begin
        w_imm = '0;
        w_err = 1'b1;
      end
    endcase
  end

  // Ready ripples backwards from out_rdy: a stage loads when empty or when its
  // current occupant is moving on this cycle.
  always_comb begin
    w_ld = '0;
    w_go = '0;
    w_go[p_nstages-1] = r_val[p_nstages-1] & out_rdy;
    w_ld[p_nstages-1] = ~r_val[p_nstages-1] | w_go[p_nstages-1];
    for (int k = p_nstages - 2; k >= 0; k--) begin
      w_go[k] = r_val[k] & w_ld[k+1];
      w_ld[k] = ~r_val[k] | w_go[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val       <= '0;
      r_err_count <= '0;
      for (int k = 0; k < p_nstages; k++) begin
        r_imm[k] <= '0;
        r_err[k] <= 1'b0;
        r_tag[k] <= '0;
      end
    end else begin
      if (w_ld[0]) begin
        r_val[0] <= in_val;
        if (in_val) begin
          r_imm[0] <= w_imm;
          r_err[0] <= w_err;
          r_tag[0] <= in_tag;
        end
      end
      for (int k = 1; k < p_nstages; k++) begin
        if (w_ld[k]) begin
          r_val[k] <= r_val[k-1];
          if (r_val[k-1]) begin
            r_imm[k] <= r_imm[k-1];
            r_err[k] <= r_err[k-1];
            r_tag[k] <= r_tag[k-1];
          end
        end
      end
      if (w_go[p_nstages-1] && r_err[p_nstages-1] && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign in_rdy    = w_ld[0];
  assign out_val   = r_val[p_nstages-1];
  assign out_imm   = r_imm[p_nstages-1];
  assign out_tag   = r_tag[p_nstages-1];
  assign out_err   = r_err[p_nstages-1];
  assign err_count = r_err_count;

endmodule

// File: tb/tb_proc_dpath_imm_gen_pipe.sv
// Self-checking bench for proc_dpath_imm_gen_pipe: scoreboard on the 32-bit instance,
// directed checks on a 64-bit instance.
module tb_proc_dpath_imm_gen_pipe;

  localparam int NS = 2;
  localparam int TW = 4;
  localparam int XL = 32;
  localparam int W  = TW + 1 + XL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [2:0]    in_imm_type;
  logic [31:0]   in_inst;
  logic [TW-1:0] in_tag;
  logic          out_val;
  logic          out_rdy;
  logic [XL-1:0] out_imm;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic [7:0]    err_count;

  logic          in_val64;
  logic          in_rdy64;
  logic [2:0]    in_imm_type64;
  logic [31:0]   in_inst64;
  logic [TW-1:0] in_tag64;
  logic          out_val64;
  logic          out_rdy64;
  logic [63:0]   out_imm64;
  logic [TW-1:0] out_tag64;
  logic          out_err64;
  logic [7:0]    err_count64;

  proc_dpath_imm_gen_pipe #(.p_xlen(XL), .p_nstages(NS), .p_tag_nbits(TW)) u_dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .in_imm_type(in_imm_type), .in_inst(in_inst), .in_tag(in_tag),
    .out_val(out_val), .out_rdy(out_rdy), .out_imm(out_imm), .out_tag(out_tag),
    .out_err(out_err), .err_count(err_count)
  );

  proc_dpath_imm_gen_pipe #(.p_xlen(64), .p_nstages(NS), .p_tag_nbits(TW)) u_dut64 (
    .clk(clk), .reset(reset), .in_val(in_val64), .in_rdy(in_rdy64),
    .in_imm_type(in_imm_type64), .in_inst(in_inst64), .in_tag(in_tag64),
    .out_val(out_val64), .out_rdy(out_rdy64), .out_imm(out_imm64), .out_tag(out_tag64),
    .out_err(out_err64), .err_count(err_count64)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_imm(input logic [2:0] t, input logic [31:0] inst);
    logic [63:0] sx;
    logic [63:0] sm;
    sx = {{32{inst[31]}}, inst};
    sm = {64{inst[31]}};
    case (t)
      3'd0: return $signed(sx) >>> 20;
      3'd1: return (($signed(sx) >>> 20) & ~64'h1F) | 64'(inst[11:7]);
      3'd2: return (sm << 12) | (64'(inst[7]) << 11) | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
      3'd3: return sx & ~64'hFFF;
      3'd4: return (sm << 20) | (64'(inst[19:12]) << 12) | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
`ifdef PROC_DPATH_IMM_GEN_ZIMM_EN
      3'd5: return 64'(inst[19:15]);
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic model_err(input logic [2:0] t);
`ifdef PROC_DPATH_IMM_GEN_ZIMM_EN
    return t >= 3'd6;
`else
    return t >= 3'd5;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [63:0]  m_imm;
    logic [W-1:0] e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_val && out_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got tag=%0h imm=%0h err=%0b, required no output", out_tag, out_imm, out_err);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, out_err, out_imm} !== e)
            $display("FAIL sb_data: got tag=%0h err=%0b imm=%0h, required tag=%0h err=%0b imm=%0h",
                     out_tag, out_err, out_imm, e[W-1 -: TW], e[XL], e[XL-1:0]);
          else
            n_pass++;
        end
      end
      if (in_val && in_rdy) begin
        m_imm = model_imm(in_imm_type, in_inst);
        exp_q.push_back({in_tag, model_err(in_imm_type), m_imm[XL-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_val = 1'b0;
    out_rdy = 1'b1;
    in_val64 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;
  endtask

  // Called aligned at posedge+1; returns aligned at posedge+1 after the accept edge.
  task automatic drive(input logic [2:0] t, input logic [31:0] inst, input logic [TW-1:0] tag);
    int n;
    in_val = 1'b1;
    in_imm_type = t;
    in_inst = inst;
    in_tag = tag;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      n_checks++;
      $display("FAIL drive_timeout: in_rdy=%0b, required 1 within 50 cycles", in_rdy);
    end
    step();
    in_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_val) && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || out_val)
      $display("FAIL drain_timeout: pending=%0d out_val=%0b, required 0/0", exp_q.size(), out_val);
    else
      n_pass++;
    step();
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    in_val = 1'b0;
    out_rdy = 1'b1;
    in_imm_type = '0;
    in_inst = '0;
    in_tag = '0;
    in_val64 = 1'b0;
    in_imm_type64 = '0;
    in_inst64 = '0;
    in_tag64 = '0;
    out_rdy64 = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_val, out_imm, out_tag, out_err, err_count} !== '0)
      $display("FAIL reset_outputs: got val=%0b imm=%0h tag=%0h err=%0b cnt=%0d, required all 0",
               out_val, out_imm, out_tag, out_err, err_count);
    else
      n_pass++;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1)
      $display("FAIL reset_release: got out_val=%0b in_rdy=%0b, required 0/1", out_val, in_rdy);
    else
      n_pass++;
    step();
  endtask

  logic [2:0]  st_type [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] st_inst [5] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h123450B7, 32'h001000EF};
  logic [31:0] st_exp  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000800};

  task automatic test_stream();
    int k;
    out_rdy = 1'b1;
    k = 0;
    for (int j = 0; j < 9; j++) begin
      if (j < 5) begin
        in_val = 1'b1;
        in_imm_type = st_type[j];
        in_inst = st_inst[j];
        in_tag = TW'(j + 1);
      end else begin
        in_val = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (out_val !== (j >= 2 && j <= 6))
        $display("FAIL stream_timing: cycle %0d out_val=%0b, required %0b", j, out_val, (j >= 2 && j <= 6));
      else
        n_pass++;
      if (out_val && k < 5) begin
        n_checks++;
        if (out_imm !== st_exp[k] || out_tag !== TW'(k + 1) || out_err !== 1'b0)
          $display("FAIL stream_value: item %0d imm=%0h tag=%0d err=%0b, required imm=%0h tag=%0d err=0",
                   k, out_imm, out_tag, out_err, st_exp[k], k + 1);
        else
          n_pass++;
        k++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic last_rdy;
    out_rdy = 1'b0;
    acc = 0;
    last_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_val = 1'b1;
      in_imm_type = st_type[acc];
      in_inst = st_inst[acc];
      in_tag = TW'(8 + acc);
      @(negedge clk);
      last_rdy = in_rdy;
      if (in_rdy) acc++;
      step();
    end
    in_val = 1'b0;
    n_checks++;
    if (acc != NS || last_rdy !== 1'b0)
      $display("FAIL bp_accepts: got %0d accepts in_rdy=%0b, required %0d and 0", acc, last_rdy, NS);
    else
      n_pass++;
    out_rdy = 1'b1;
    for (int j = 0; j <= NS; j++) begin
      @(negedge clk);
      n_checks++;
      if (out_val !== (j < NS))
        $display("FAIL bp_drain: cycle %0d out_val=%0b, required %0b", j, out_val, (j < NS));
      else
        n_pass++;
      step();
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(3'd6, 32'hDEADBEEF, 4'h3);
    wait_drain();
    n_checks++;
    if (err_count !== 8'd1)
      $display("FAIL illegal_single_count: got %0d, required 1", err_count);
    else
      n_pass++;
    for (int i = 0; i < 300; i++)
`ifdef PROC_DPATH_IMM_GEN_ZIMM_EN
      drive(3'($urandom_range(6, 7)), $urandom, TW'($urandom_range(0, 15)));
`else
      drive(3'($urandom_range(5, 7)), $urandom, TW'($urandom_range(0, 15)));
`endif
    wait_drain();
    n_checks++;
    if (err_count !== 8'd255)
      $display("FAIL illegal_saturate: got %0d, required 255", err_count);
    else
      n_pass++;
    drive(3'd7, 32'h0, 4'h1);
    wait_drain();
    n_checks++;
    if (err_count !== 8'd255)
      $display("FAIL illegal_hold: got %0d, required 255", err_count);
    else
      n_pass++;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(3'd6, $urandom, TW'(i));
    wait_drain();
    n_checks++;
    if (err_count !== 8'd3)
      $display("FAIL mid_pre_count: got %0d, required 3", err_count);
    else
      n_pass++;
    out_rdy = 1'b0;
    drive(3'd0, 32'hFFF00093, 4'hA);
    drive(3'd3, 32'h123450B7, 4'hB);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_val !== 1'b0 || err_count !== 8'd0)
      $display("FAIL mid_async: got out_val=%0b cnt=%0d, required 0/0", out_val, err_count);
    else
      n_pass++;
    @(negedge clk);
    step();
    reset = 1'b0;
    out_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 0) begin
        in_val = 1'b1;
        in_imm_type = 3'd1;
        in_inst = 32'hFE20AE23;
        in_tag = 4'h5;
      end else begin
        in_val = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (out_val !== (j == NS) || (j == 0 && in_rdy !== 1'b1))
        $display("FAIL mid_latency: cycle %0d out_val=%0b in_rdy=%0b, required out_val=%0b", j, out_val, in_rdy, (j == NS));
      else
        n_pass++;
      step();
    end
  endtask

  task automatic test_zimm();
    int n;
    logic [31:0] e_imm;
    logic        e_err;
`ifdef PROC_DPATH_IMM_GEN_ZIMM_EN
    e_imm = 32'h1F;
    e_err = 1'b0;
`else
    e_imm = 32'h0;
    e_err = 1'b1;
`endif
    out_rdy = 1'b1;
    drive(3'd5, 32'h000FD073, 4'h7);
    n = 0;
    @(negedge clk);
    while (!out_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (out_val !== 1'b1 || out_imm !== e_imm || out_err !== e_err)
      $display("FAIL zimm: got val=%0b imm=%0h err=%0b, required val=1 imm=%0h err=%0b", out_val, out_imm, out_err, e_imm, e_err);
    else
      n_pass++;
    step();
    wait_drain();
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    logic            prev_stall;
    logic [W-1:0]    prev_out;
    logic [2:0]      t;
    sent = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    in_val = 1'b0;
    while (sent < 150 && cyc < 3000) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      if (!in_val) begin
        t = 3'($urandom_range(0, 7));
        in_imm_type = t;
        in_inst = $urandom;
        in_tag = TW'($urandom_range(0, 15));
        in_val = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (out_val !== 1'b1 || {out_tag, out_err, out_imm} !== prev_out)
          $display("FAIL stall_stable: got val=%0b tag=%0h imm=%0h, required held tag=%0h imm=%0h",
                   out_val, out_tag, out_imm, prev_out[W-1 -: TW], prev_out[XL-1:0]);
        else
          n_pass++;
      end
      prev_stall = out_val && !out_rdy;
      prev_out = {out_tag, out_err, out_imm};
      if (in_val && in_rdy) begin
        sent++;
        step();
        in_val = 1'b0;
      end else begin
        step();
      end
      cyc++;
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    wait_drain();
  endtask

  task automatic test_xlen64();
    logic [31:0] v_inst [2] = '{32'hFFF00093, 32'h800000B7};
    logic [2:0]  v_type [2] = '{3'd0, 3'd3};
    logic [63:0] v_exp  [2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000};
    int n;
    out_rdy64 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_val64 = 1'b1;
      in_imm_type64 = v_type[i];
      in_inst64 = v_inst[i];
      in_tag64 = TW'(i + 2);
      @(negedge clk);
      step();
      in_val64 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_val64 && n < 20) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (out_val64 !== 1'b1 || out_imm64 !== v_exp[i] || out_err64 !== 1'b0 || out_tag64 !== TW'(i + 2))
        $display("FAIL xlen64_%0d: got val=%0b imm=%0h err=%0b tag=%0h, required imm=%0h err=0 tag=%0h",
                 i, out_val64, out_imm64, out_err64, out_tag64, v_exp[i], i + 2);
      else
        n_pass++;
      step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_illegal();
    test_reset_midstream();
    test_zimm();
    test_random();
    test_xlen64();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_dpath_imm_gen_pipe.md
Name: proc_dpath_imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the processor datapath.
- Decodes I/S/B/U/J immediates (optional Z-type CSR uimm) from a 32-bit instruction and sign-extends to a configurable datapath width.
- Results move through an elastic val/rdy pipeline of configurable depth, with an opaque tag carried alongside each result.
- Flags illegal immediate types and keeps a saturating count of how many were delivered.

Parameters:
- p_xlen, 32, output immediate width; legal values ≥ 32; sign-extension is always from inst[31].
- p_nstages, 2, number of pipeline register stages; legal range 1..4.
- p_tag_nbits, 4, width of the sideband tag carried unchanged with each transaction.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  input transaction valid
- in_rdy  output  1  input ready
- in_imm_type  input  3  0=I 1=S 2=B 3=U 4=J 5=Z (feature) 6,7=illegal
- in_inst  input  32  instruction word
- in_tag  input  p_tag_nbits  sideband tag
- out_val  output  1  output valid
- out_rdy  input  1  output ready
- out_imm  output  p_xlen  generated immediate
- out_tag  output  p_tag_nbits  tag of the delivered transaction
- out_err  output  1  delivered transaction had an illegal type
- err_count  output  8  saturating count of delivered illegal transactions

Behaviour:
- Reset (asynchronous, active-high):
  - clears all stage valid bits, stage data, out_imm, out_tag, out_err and err_count to 0.
  - Reset asserted mid-stream discards every in-flight transaction; out_val is 0 while reset is high and in the first cycle after it.
- Decode is combinational at the input, with s = inst[31] replicated to p_xlen:
  - I: s, inst[30:20]
  - S: s, inst[30:25], inst[11:7]
  - B: s, inst[7], inst[30:25], inst[11:8], 0
  - U: s above bit 31, then inst[31:12], 12'b0
  - J: s, inst[19:12], inst[20], inst[30:21], 0
- Illegal type: imm = 0 and err = 1. Legal types: err = 0.
- Stage 0 registers {imm, err, tag}. Later stages copy the previous stage. Output ports are driven directly from the last stage.
- Stage k may load when its valid is 0 or the stage downstream of it is advancing; the last stage advances when out_val & out_rdy.
- in_rdy = stage-0 load enable. It is combinational from out_rdy through the stage valids; no registered skid.
- Latency is exactly p_nstages cycles from an accepted input to out_val when unstalled. Throughput is one transaction per cycle with continuous out_rdy.
- When full and out_rdy=0: in_rdy=0 and all stages hold. No transaction is lost, duplicated or reordered.
- Simultaneous accept and deliver when full with out_rdy=1: both occur in the same cycle and occupancy stays constant.
- Outputs are stable while out_val=1 and out_rdy=0.
- err_count increments on each cycle with out_val & out_rdy & out_err. It saturates at 255 and never wraps.
- in_* are ignored while in_val=0. Stage data is only meaningful when its valid bit is set.

Optional Feature:
- Macro: PROC_DPATH_IMM_GEN_ZIMM_EN.
  - Defined: imm_type 5 is legal; imm = zero-extended inst[19:15], err = 0.
  - Undefined: imm_type 5 is illegal, same as 6 and 7 (imm = 0, err = 1, counted in err_count).

Test Plan:
- Stream, p_nstages=2, out_rdy=1, tags 1..5:
  - I 0xFFF00093 -> 0xFFFFFFFF
  - S 0xFE20AE23 -> 0xFFFFFFFC
  - B 0x00000463 -> 0x00000008
  - U 0x123450B7 -> 0x12345000
  - J 0x001000EF -> 0x00000800
  - Required: outputs on consecutive cycles starting 2 cycles after the first accept; out_tag 1..5 in order; out_err=0.
- Backpressure:
  - Hold out_rdy=0 for 4 cycles while in_val=1. in_rdy must drop after exactly p_nstages accepts.
  - Release out_rdy: all results emerge in order with no gaps, duplicates or losses.
- Illegal types:
  - imm_type 6 -> out_imm 0, out_err 1, err_count 1.
  - 300 back-to-back illegal transactions -> err_count 255, held.
- p_xlen=64:
  - I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF
  - U 0x800000B7 -> 0xFFFFFFFF80000000
- Reset mid-stream:
  - Pulse reset with 2 transactions in flight and err_count=3.
  - Required: out_val=0 immediately (asynchronous); err_count=0; the next accepted input emerges after p_nstages cycles.
- Feature test, type 5 with inst 0x000FD073 (rs1 field=31):
  - With the macro defined: out_imm 0x1F, out_err 0.
  - Without it: out_imm 0, out_err 1.
